dma_controller: RTL
===================

DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 Parameters: ADDR_W, 8, address width; DATA_W, 8, data width; CNT_W, 8, transfer-count width.
REQ-002 clock  in  1  single clock, all state on rising edge.
REQ-003 enable_n  in  1  reset, asynchronous, active-low.
REQ-004 cfg_src, cfg_dst  in  ADDR_W each  source/destination start addresses, sampled on start.
REQ-005 cfg_count  in  CNT_W  number of bytes to move, sampled on start.
REQ-006 start  in  1  one-cycle request to begin a transfer.
REQ-007 HOLD  out  1  bus request to processor; HLDA  in  1  bus grant from processor.
REQ-008 address_line  out  ADDR_W  memory address; control_line  out  1  1 = read, 0 = write.
REQ-009 data_in  in  DATA_W  memory read data; data_out  out  DATA_W  write data; data_oe  out  1  data_out valid on bus.
REQ-010 bus_oe  out  1  address_line/control_line owned by this block (external tristate enable).
REQ-011 busy, done, err  out  1 each  status; done is a one-cycle pulse, err is sticky.

Function
REQ-012 FSM states: IDLE, REQ, READ, CAPT, WRITE, NEXT, REL.
REQ-013 IDLE: start with cfg_count!=0 latches src/dst/count, sets busy=1, clears err, goes to REQ; start with cfg_count==0 pulses done next cycle, no HOLD.
REQ-014 start while busy=1 is ignored.
REQ-015 REQ: HOLD=1; stays until HLDA=1 sampled, then READ next cycle.
REQ-016 READ: bus_oe=1, control_line=1, address_line=src, one cycle.
REQ-017 CAPT: address held, data_in latched into byte register at end of cycle.
REQ-018 WRITE: control_line=0, address_line=dst, data_out=byte register, data_oe=1, one cycle.
REQ-019 NEXT: src+1, dst+1 modulo 2^ADDR_W (8'hFF wraps to 8'h00), count-1; count==0 -> REL, else per REQ-027.
REQ-020 Per-byte latency: 4 cycles READ->NEXT after grant.
REQ-021 REL: HOLD=0, bus_oe=0, data_oe=0, busy=0, done=1 for one cycle, then IDLE.
REQ-022 HLDA falling in READ/CAPT/WRITE/NEXT: bus_oe, data_oe, HOLD drop next cycle, err=1, busy=0, no done, -> IDLE; byte in progress not written.
REQ-023 bus_oe=0 and data_oe=0 in IDLE, REQ, REL.

Reset
REQ-024 enable_n=0 immediately forces IDLE, HOLD=0, address_line=0, control_line=0, data_out=0, data_oe=0, bus_oe=0, busy=0, done=0, err=0, counters 0.
REQ-025 Reset mid-transfer abandons the transfer with no done pulse; first start after reset release behaves as from power-up.

Configuration
REQ-026 Macro DMA_BURST_EN selects transfer mode.
REQ-027 Defined: NEXT with count!=0 -> READ, HOLD held for entire block. Undefined (single mode): NEXT with count!=0 -> REQ via one cycle with HOLD=0, re-requesting bus per byte.

Structure
REQ-028 Package dma_pkg holds the state enumeration, control_line READ/WRITE constants and default widths.
REQ-029 One sub-module dma_xfer_counter: loadable src/dst/count registers with increment/decrement and count-zero flag.

Verification
REQ-030 src=8'h10, dst=8'h40, count=3, mem[10..12]=AA,BB,CC, HLDA one cycle after HOLD -> mem[40..42]=AA,BB,CC, one done pulse, busy low after.
REQ-031 src=8'hFE, dst=8'h00, count=4 -> reads FE,FF,00,01, writes 00..03 (address wrap).
REQ-032 HLDA held low 10 cycles after start -> HOLD=1 throughout, no bus_oe, transfer proceeds once HLDA=1.
REQ-033 HLDA dropped during second byte's WRITE-preceding CAPT, count=5 -> one byte written, err=1, busy=0, no done.
REQ-034 start with count=0 -> done next cycle, HOLD never asserted; start during busy -> latched config unchanged.
REQ-035 enable_n pulsed low mid-READ -> all outputs at reset values same cycle; run both with and without DMA_BURST_EN, checking HOLD per-byte toggling only without it.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA controller: FSM state encoding, bus direction
// constants and default widths.
package dma_pkg;

  localparam int DMA_ADDR_W = 8;
  localparam int DMA_DATA_W = 8;
  localparam int DMA_CNT_W  = 8;

  localparam logic CTL_READ  = 1'b1;
  localparam logic CTL_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5,
    ST_REL   = 3'd6
  } dma_state_t;

endpackage

// File: rtl/dma_xfer_counter.sv
// Source/destination address and remaining-byte registers for one DMA block,
// loaded at start and stepped once per moved byte.
module dma_xfer_counter
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int CNT_W  = DMA_CNT_W
) (
  input  logic              clock,
  input  logic              enable_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_src,
  input  logic [ADDR_W-1:0] load_dst,
  input  logic [CNT_W-1:0]  load_count,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic              count_zero
);

  logic [CNT_W-1:0] count_r;

  // Load on start, then advance both addresses (wrapping) and consume one byte per step.
  always_ff @(posedge clock or negedge enable_n) begin
    if (!enable_n) begin
      src     <= '0;
      dst     <= '0;
      count_r <= '0;
    end else if (load) begin
      src     <= load_src;
      dst     <= load_dst;
      count_r <= load_count;
    end else if (step) begin
      src     <= src + ADDR_W'(1);
      dst     <= dst + ADDR_W'(1);
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count_zero = (count_r == '0);

endmodule

// File: rtl/dma_controller.sv
// Single-channel memory-to-memory DMA controller with HOLD/HLDA bus arbitration.
// Define DMA_BURST_EN to keep the bus for a whole block; default re-requests per byte.
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W,
  parameter int CNT_W  = DMA_CNT_W
) (
  input  logic              clock,
  input  logic              enable_n,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              start,
  output logic              HOLD,
  input  logic              HLDA,
  output logic [ADDR_W-1:0] address_line,
  output logic              control_line,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              bus_oe,
  output logic              busy,
  output logic              done,
  output logic              err
);

  dma_state_t        state_r, state_s;
  logic              regap_r, regap_s;
  logic [DATA_W-1:0] byte_r;
  logic              load_s, step_s, capture_s, abort_s, zero_done_s;
  logic              hold_s, bus_oe_s, data_oe_s, ctl_s, busy_s, done_s, err_s;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] src, dst;
  logic              count_zero;

  dma_xfer_counter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_counter (
    .clock      (clock),
    .enable_n   (enable_n),
    .load       (load_s),
    .step       (step_s),
    .load_src   (cfg_src),
    .load_dst   (cfg_dst),
    .load_count (cfg_count),
    .src        (src),
    .dst        (dst),
    .count_zero (count_zero)
  );

  // Next-state decode, then next values of every (registered) bus/status output.
  always_comb begin
    state_s     = state_r;
    regap_s     = 1'b0;
    load_s      = 1'b0;
    step_s      = 1'b0;
    capture_s   = 1'b0;
    abort_s     = 1'b0;
    zero_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (cfg_count != '0) begin
            load_s  = 1'b1;
            state_s = ST_REQ;
          end else begin
            zero_done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      // The first REQ cycle after a per-byte release keeps HOLD low and ignores HLDA.
      ST_REQ: begin
        if (regap_r) begin
          state_s = ST_REQ;
        end else if (HLDA) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_READ, ST_CAPT, ST_WRITE, ST_NEXT: begin
        if (!HLDA) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else if (state_r == ST_READ) begin
          state_s = ST_CAPT;
        end else if (state_r == ST_CAPT) begin
          capture_s = 1'b1;
          state_s   = ST_WRITE;
        end else if (state_r == ST_WRITE) begin
          step_s  = 1'b1;
          state_s = ST_NEXT;
        end else if (count_zero) begin
          state_s = ST_REL;
        end else begin
`ifdef DMA_BURST_EN
          state_s = ST_READ;
`else
          state_s = ST_REQ;
          regap_s = 1'b1;
`endif
        end
      end
      ST_REL:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    hold_s    = 1'b0;
    bus_oe_s  = 1'b0;
    data_oe_s = 1'b0;
    ctl_s     = CTL_WRITE;
    busy_s    = 1'b0;
    addr_s    = '0;
    done_s    = zero_done_s;
    case (state_s)
      ST_IDLE: busy_s = 1'b0;
      ST_REQ: begin
        hold_s = ~regap_s;
        busy_s = 1'b1;
      end
      ST_READ, ST_CAPT: begin
        hold_s   = 1'b1;
        bus_oe_s = 1'b1;
        ctl_s    = CTL_READ;
        addr_s   = src;
        busy_s   = 1'b1;
      end
      ST_WRITE: begin
        hold_s    = 1'b1;
        bus_oe_s  = 1'b1;
        data_oe_s = 1'b1;
        addr_s    = dst;
        busy_s    = 1'b1;
      end
      ST_NEXT: begin
        hold_s   = 1'b1;
        bus_oe_s = 1'b1;
        addr_s   = address_line;
        busy_s   = 1'b1;
      end
      ST_REL:  done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase

    if (load_s) begin
      err_s = 1'b0;
    end else if (abort_s) begin
      err_s = 1'b1;
    end else begin
      err_s = err;
    end
  end

  // State, capture byte and all outputs; the async reset clears everything at once.
  always_ff @(posedge clock or negedge enable_n) begin
    if (!enable_n) begin
      state_r      <= ST_IDLE;
      regap_r      <= 1'b0;
      byte_r       <= '0;
      HOLD         <= 1'b0;
      bus_oe       <= 1'b0;
      data_oe      <= 1'b0;
      control_line <= 1'b0;
      address_line <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_r      <= state_s;
      regap_r      <= regap_s;
      HOLD         <= hold_s;
      bus_oe       <= bus_oe_s;
      data_oe      <= data_oe_s;
      control_line <= ctl_s;
      address_line <= addr_s;
      busy         <= busy_s;
      done         <= done_s;
      err          <= err_s;
      if (capture_s) begin
        byte_r <= data_in;
      end else begin
        byte_r <= byte_r;
      end
    end
  end

  assign data_out = byte_r;

endmodule
